// File: rtl/md_sequencer.sv
// Multicycle mul/div sequencer: stalls the front end while the multdiv unit runs.
// Optional BUSY watchdog enabled by defining MD_TIMEOUT_EN.
module md_sequencer #(
   parameter int TIMEOUT_CYCLES = 40
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        x_typeR,
   input  logic [4:0]  x_aluOp,
   input  logic [4:0]  x_rd,
   input  logic [31:0] x_opA,
   input  logic [31:0] x_opB,
   input  logic        data_resultRDY,
   input  logic        data_exception,
   input  logic [31:0] data_result,
   output logic        ctrl_MULT,
   output logic        ctrl_DIV,
   output logic [31:0] md_opA,
   output logic [31:0] md_opB,
   output logic        stall,
   output logic        wb_valid,
   output logic [4:0]  wb_reg,
   output logic [31:0] wb_data
);

   typedef enum logic [1:0] {IDLE, START, BUSY, WB} state_t;

   state_t      state, nextState;
   logic        isMd;
   logic        opDiv;
   logic        excQ;
   logic [4:0]  rdQ;
   logic [31:0] resultQ;
   logic [5:0]  count;
   logic        issue, capture, forceExc, timeoutHit;

   assign isMd = x_typeR & ((x_aluOp == 5'b00110) | (x_aluOp == 5'b00111));

`ifdef MD_TIMEOUT_EN
   // count holds the number of BUSY cycles already completed
   assign timeoutHit = (count >= 6'(TIMEOUT_CYCLES - 1));
`else
   logic unusedTimeout;
   assign unusedTimeout = (TIMEOUT_CYCLES != 0);
   assign timeoutHit = 1'b0;
`endif

   always_comb begin
      nextState = state;
      issue     = 1'b0;
      capture   = 1'b0;
      forceExc  = 1'b0;
      stall     = 1'b0;
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      wb_valid  = 1'b0;
      wb_reg    = 5'd0;
      wb_data   = 32'd0;
      unique case (state)
         IDLE: begin
            stall = isMd & ~reset;
            if (isMd) begin
               issue     = 1'b1;
               nextState = START;
            end
         end
         START: begin
            stall     = 1'b1;
            ctrl_MULT = ~opDiv;
            ctrl_DIV  = opDiv;
            nextState = BUSY;
         end
         BUSY: begin
            stall = 1'b1;
            if (data_resultRDY) begin
               capture   = 1'b1;
               nextState = WB;
            end else if (timeoutHit) begin
               forceExc  = 1'b1;
               nextState = WB;
            end
         end
         WB: begin
            nextState = IDLE;
            if (excQ) begin
               wb_valid = 1'b1;
               wb_reg   = 5'd30;
               wb_data  = opDiv ? 32'd5 : 32'd4;
            end else begin
               wb_valid = |rdQ;
               wb_reg   = rdQ;
               wb_data  = resultQ;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         opDiv   <= 1'b0;
         excQ    <= 1'b0;
         rdQ     <= 5'd0;
         md_opA  <= 32'd0;
         md_opB  <= 32'd0;
         resultQ <= 32'd0;
         count   <= 6'd0;
      end else begin
         state <= nextState;
         if (issue) begin
            md_opA <= x_opA;
            md_opB <= x_opB;
            rdQ    <= x_rd;
            opDiv  <= x_aluOp[0];
            excQ   <= 1'b0;
            count  <= 6'd0;
         end
         if (state == BUSY && count != 6'd63)
            count <= count + 6'd1;
         if (capture) begin
            resultQ <= data_result;
            excQ    <= data_exception;
         end
         if (forceExc)
            excQ <= 1'b1;
      end
   end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer; writeback scoreboard filled at issue.
module tb_md_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        x_typeR;
   logic [4:0]  x_aluOp;
   logic [4:0]  x_rd;
   logic [31:0] x_opA, x_opB;
   logic        data_resultRDY;
   logic        data_exception;
   logic [31:0] data_result;
   logic        ctrl_MULT, ctrl_DIV;
   logic [31:0] md_opA, md_opB;
   logic        stall;
   logic        wb_valid;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
   } wb_t;

   wb_t sbQ[$];
   int  total = 0;
   int  bad = 0;
   int  mulPulses = 0;
   int  divPulses = 0;
   int  wbSeen = 0;

   always #5 clock = ~clock;

   md_sequencer #(.TIMEOUT_CYCLES(40)) dut (
      .clock(clock),
      .reset(reset),
      .x_typeR(x_typeR),
      .x_aluOp(x_aluOp),
      .x_rd(x_rd),
      .x_opA(x_opA),
      .x_opB(x_opB),
      .data_resultRDY(data_resultRDY),
      .data_exception(data_exception),
      .data_result(data_result),
      .ctrl_MULT(ctrl_MULT),
      .ctrl_DIV(ctrl_DIV),
      .md_opA(md_opA),
      .md_opB(md_opB),
      .stall(stall),
      .wb_valid(wb_valid),
      .wb_reg(wb_reg),
      .wb_data(wb_data)
   );

   task automatic idleX();
      x_typeR = 1'b0;
      x_aluOp = 5'd0;
      x_rd    = 5'd0;
      x_opA   = 32'd0;
      x_opB   = 32'd0;
   endtask

   // One full operation from issue through WB; k = RDY cycle offset (>= 2).
   task automatic doOp(input bit isDiv, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b,
                       input int k, input bit exc, input logic [31:0] res);
      wb_t e;
      wb_t got;
      @(posedge clock); #1;
      x_typeR = 1'b1;
      x_aluOp = isDiv ? 5'b00111 : 5'b00110;
      x_rd    = rd;
      x_opA   = a;
      x_opB   = b;
      if (exc) begin
         e.r = 5'd30;
         e.d = isDiv ? 32'd5 : 32'd4;
         sbQ.push_back(e);
      end else if (rd != 5'd0) begin
         e.r = rd;
         e.d = res;
         sbQ.push_back(e);
      end
      @(negedge clock);
      total++;
      if (stall !== 1'b1 || ctrl_MULT !== 1'b0 || ctrl_DIV !== 1'b0 || wb_valid !== 1'b0) begin
         bad++;
         $display("FAIL issue: stall=%b mult=%b div=%b wbv=%b required 1 0 0 0",
                  stall, ctrl_MULT, ctrl_DIV, wb_valid);
      end
      @(posedge clock); #1;
      @(negedge clock);
      if (ctrl_MULT === 1'b1) mulPulses++;
      if (ctrl_DIV === 1'b1) divPulses++;
      total++;
      if ({ctrl_MULT, ctrl_DIV} !== {~isDiv, isDiv}) begin
         bad++;
         $display("FAIL start_ctrl: mult/div=%b%b required %b%b",
                  ctrl_MULT, ctrl_DIV, ~isDiv, isDiv);
      end
      total++;
      if (md_opA !== a || md_opB !== b || stall !== 1'b1) begin
         bad++;
         $display("FAIL start_ops: opA=%0d opB=%0d stall=%b required %0d %0d 1",
                  md_opA, md_opB, stall, a, b);
      end
      for (int c = 2; c <= k; c++) begin
         @(posedge clock); #1;
         if (c == k) begin
            data_resultRDY = 1'b1;
            data_exception = exc;
            data_result    = res;
         end
         @(negedge clock);
         total++;
         if (stall !== 1'b1 || ctrl_MULT !== 1'b0 || ctrl_DIV !== 1'b0 || wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL busy c=%0d: stall=%b mult=%b div=%b wbv=%b required 1 0 0 0",
                     c, stall, ctrl_MULT, ctrl_DIV, wb_valid);
         end
      end
      @(posedge clock); #1;
      data_resultRDY = 1'b0;
      data_exception = 1'b0;
      data_result    = $urandom;
      @(negedge clock);
      total++;
      if (stall !== 1'b0 || ctrl_MULT !== 1'b0 || ctrl_DIV !== 1'b0) begin
         bad++;
         $display("FAIL wb_stall: stall=%b mult=%b div=%b required 0 0 0",
                  stall, ctrl_MULT, ctrl_DIV);
      end
      total++;
      if (md_opA !== a || md_opB !== b) begin
         bad++;
         $display("FAIL wb_ops_held: opA=%0d opB=%0d required %0d %0d",
                  md_opA, md_opB, a, b);
      end
      total++;
      if (wb_valid === 1'b1) begin
         wbSeen++;
         if (sbQ.size() == 0) begin
            bad++;
            $display("FAIL wb_unexpected: reg=%0d data=%0d required no write",
                     wb_reg, wb_data);
         end else begin
            got = sbQ.pop_front();
            if (wb_reg !== got.r || wb_data !== got.d) begin
               bad++;
               $display("FAIL wb_value: reg=%0d data=%0d required %0d %0d",
                        wb_reg, wb_data, got.r, got.d);
            end
         end
      end else if (sbQ.size() != 0) begin
         got = sbQ.pop_front();
         bad++;
         $display("FAIL wb_missing: wb_valid=%b required write r%0d=%0d",
                  wb_valid, got.r, got.d);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      x_typeR = 1'b1;
      x_aluOp = 5'b00110;
      x_rd    = 5'd5;
      x_opA   = 32'd11;
      x_opB   = 32'd12;
      data_resultRDY = 1'b0;
      data_exception = 1'b0;
      data_result    = 32'd0;
      repeat (2) @(negedge clock);
      total++;
      if ({stall, ctrl_MULT, ctrl_DIV, wb_valid} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_ctrl: stall/mult/div/wbv=%b required 0000",
                  {stall, ctrl_MULT, ctrl_DIV, wb_valid});
      end
      total++;
      if (md_opA !== 32'd0 || md_opB !== 32'd0 || wb_reg !== 5'd0 || wb_data !== 32'd0) begin
         bad++;
         $display("FAIL reset_data: opA=%0d opB=%0d reg=%0d data=%0d required 0",
                  md_opA, md_opB, wb_reg, wb_data);
      end
      @(posedge clock); #1;
      idleX();
      reset = 1'b0;
   endtask

   task automatic test_mul();
      doOp(1'b0, 5'd5, 32'd7, 32'd6, 6, 1'b0, 32'd42);
   endtask

   task automatic test_div_exception();
      @(posedge clock); #1;
      idleX();
      doOp(1'b1, 5'd3, 32'd9, 32'd0, 3, 1'b1, 32'hDEAD_BEEF);
      @(posedge clock); #1;
      idleX();
      doOp(1'b0, 5'd9, 32'h7FFF_FFFF, 32'd4, 4, 1'b1, 32'h1234);
   endtask

   task automatic test_mul_r0();
      @(posedge clock); #1;
      idleX();
      doOp(1'b0, 5'd0, 32'd3, 32'd4, 2, 1'b0, 32'd12);
   endtask

   task automatic test_back_to_back();
      int m0, w0;
      @(posedge clock); #1;
      idleX();
      m0 = mulPulses;
      w0 = wbSeen;
      doOp(1'b0, 5'd7, 32'd100, 32'd3, 4, 1'b0, 32'd300);
      doOp(1'b0, 5'd8, 32'd5, 32'd5, 2, 1'b0, 32'd25);
      total++;
      if (mulPulses - m0 !== 2 || wbSeen - w0 !== 2) begin
         bad++;
         $display("FAIL b2b_counts: pulses=%0d writes=%0d required 2 2",
                  mulPulses - m0, wbSeen - w0);
      end
      doOp(1'b1, 5'd12, 32'd100, 32'd7, 5, 1'b0, 32'd14);
   endtask

   task automatic test_rdy_ignored();
      @(posedge clock); #1;
      idleX();
      data_resultRDY = 1'b1;
      data_result    = 32'd77;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         total++;
         if (wb_valid !== 1'b0 || stall !== 1'b0 || ctrl_MULT !== 1'b0) begin
            bad++;
            $display("FAIL idle_rdy: wbv=%b stall=%b mult=%b required 0 0 0",
                     wb_valid, stall, ctrl_MULT);
         end
         @(posedge clock); #1;
      end
      data_resultRDY = 1'b0;
   endtask

   task automatic test_reset_busy();
      @(posedge clock); #1;
      x_typeR = 1'b1;
      x_aluOp = 5'b00110;
      x_rd    = 5'd6;
      x_opA   = 32'd21;
      x_opB   = 32'd2;
      repeat (3) begin
         @(posedge clock); #1;
      end
      reset = 1'b1;
      #1;
      total++;
      if ({stall, ctrl_MULT, ctrl_DIV, wb_valid} !== 4'b0000 ||
          md_opA !== 32'd0 || md_opB !== 32'd0) begin
         bad++;
         $display("FAIL reset_busy: stall/mult/div/wbv=%b opA=%0d opB=%0d required 0",
                  {stall, ctrl_MULT, ctrl_DIV, wb_valid}, md_opA, md_opB);
      end
      @(posedge clock); #1;
      reset = 1'b0;
      idleX();
      data_resultRDY = 1'b1;
      data_result    = 32'd42;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         total++;
         if (wb_valid !== 1'b0 || stall !== 1'b0 || ctrl_MULT !== 1'b0) begin
            bad++;
            $display("FAIL post_reset: wbv=%b stall=%b mult=%b required 0 0 0",
                     wb_valid, stall, ctrl_MULT);
         end
         @(posedge clock); #1;
      end
      data_resultRDY = 1'b0;
      doOp(1'b0, 5'd6, 32'd21, 32'd2, 3, 1'b0, 32'd42);
   endtask

`ifdef MD_TIMEOUT_EN
   task automatic test_timeout();
      wb_t e;
      @(posedge clock); #1;
      x_typeR = 1'b1;
      x_aluOp = 5'b00110;
      x_rd    = 5'd4;
      x_opA   = 32'd1;
      x_opB   = 32'd1;
      e.r = 5'd30;
      e.d = 32'd4;
      sbQ.push_back(e);
      for (int c = 0; c <= 41; c++) begin
         @(negedge clock);
         total++;
         if (stall !== 1'b1 || wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL timeout_busy c=%0d: stall=%b wbv=%b required 1 0",
                     c, stall, wb_valid);
         end
         @(posedge clock); #1;
      end
      @(negedge clock);
      total++;
      if (stall !== 1'b0 || wb_valid !== 1'b1 || wb_reg !== e.r || wb_data !== e.d) begin
         bad++;
         $display("FAIL timeout_wb: stall=%b wbv=%b reg=%0d data=%0d required 0 1 30 4",
                  stall, wb_valid, wb_reg, wb_data);
      end
      void'(sbQ.pop_front());
      @(posedge clock); #1;
      idleX();
      data_resultRDY = 1'b1;
      repeat (2) begin
         @(negedge clock);
         total++;
         if (wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL timeout_stray: wbv=%b required 0", wb_valid);
         end
         @(posedge clock); #1;
      end
      data_resultRDY = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_mul();
      test_div_exception();
      test_mul_r0();
      test_back_to_back();
      test_rdy_ignored();
      test_reset_busy();
`ifdef MD_TIMEOUT_EN
      test_timeout();
`endif
      total++;
      if (sbQ.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: pending=%0d required 0", sbQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multicycle multiply/divide sequencer for the pipelined processor. It sits beside the execute stage and detects R-type `mul`/`div` instructions. While the shared multdiv unit iterates, it freezes the front of the pipeline. When the unit finishes, it injects a single writeback of either the result or the `$rstatus` exception code. It owns all `ctrl_MULT`/`ctrl_DIV` handshaking so the decode/control logic stays purely combinational.

## Interface
- TIMEOUT_CYCLES, 40, maximum BUSY cycles before a forced exception (used only with MD_TIMEOUT_EN)
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- x_typeR  in  1  instruction in X is R-type (opcode 00000)
- x_aluOp  in  5  ALU op of the X instruction: 00110 = mul, 00111 = div
- x_rd  in  5  destination register of the X instruction
- x_opA, x_opB  in  32  regfile operands of the X instruction
- data_resultRDY  in  1  multdiv unit result valid
- data_exception  in  1  multdiv unit overflow / divide-by-zero, valid with RDY
- data_result  in  32  multdiv unit result
- ctrl_MULT, ctrl_DIV  out  1  one-cycle start pulses to the multdiv unit
- md_opA, md_opB  out  32  latched operands, held stable START through WB
- stall  out  1  freeze PC, F/D and D/X latches; insert bubble into X/M
- wb_valid  out  1  regfile write request (one cycle)
- wb_reg  out  5  write address
- wb_data  out  32  write data

## Operation
- is_md = x_typeR & (x_aluOp == 00110 | x_aluOp == 00111).
- State IDLE:
  - stall = is_md (combinational).
  - On is_md: latch opA, opB, rd and op (mul/div); go to START.
- State START:
  - Exactly one of ctrl_MULT or ctrl_DIV is 1, matching the latched op.
  - stall = 1. Go to BUSY.
- State BUSY:
  - stall = 1. A 6-bit counter increments each cycle.
  - On data_resultRDY: capture result and exception; go to WB.
- State WB:
  - stall = 0. The X instruction advances.
  - is_md is ignored, because it is the same instruction.
  - Go to IDLE.
- WB outputs, no exception: wb_valid = (rd != 0), wb_reg = rd, wb_data = result.
- WB outputs, exception: wb_valid = 1, wb_reg = 30. wb_data = 4 for mul, 5 for div (zero-extended to 32 bits).
- wb_valid = 0 in every state other than WB.
- data_resultRDY is ignored in IDLE, START and WB.
- Reset values:
  - state = IDLE; the counter and all latches are cleared.
  - Every output is 0, including stall, ctrl_*, wb_*, and md_op* = 0.
- Reset asserted mid-operation discards the operation: no pulse is issued and no writeback occurs.

## Timing
- Issue at cycle T (IDLE, is_md): stall = 1 in T.
- START at T+1: ctrl_* = 1 and md_op* are valid.
- BUSY from T+2. If RDY is seen at cycle T+k (k ≥ 2), WB is at T+k+1 and IDLE at T+k+2.
- Minimum occupancy is 4 cycles.
- stall is high from T through T+k inclusive, and low in WB.
- A back-to-back `mul` entering X at WB+1 is accepted in IDLE at that cycle, with no lost cycle.
- ctrl_* is never high for more than one consecutive cycle.

## Configuration
- MD_TIMEOUT_EN defined:
  - If the BUSY counter reaches TIMEOUT_CYCLES without RDY, go to WB with exception forced.
  - WB then writes r30 = 4 or 5 as for a real exception.
  - A later stray RDY is ignored.
- MD_TIMEOUT_EN undefined:
  - No watchdog; BUSY waits indefinitely.
  - The counter still runs and saturates at 63.

## Test plan
- mul r5 = 7 × 6, unit returns RDY at T+6 with result 42 -> ctrl_MULT high only at T+1. stall high T..T+6. wb_valid/wb_reg = 5/wb_data = 42 at T+7 only.
- div r3 = 9 / 0, RDY with exception at T+3 -> WB at T+4 writes r30 = 5. r3 is not written.
- mul r0 = 3 × 4, no exception -> stall sequence as normal, wb_valid = 0 in WB.
- Two back-to-back muls -> the second issue is detected at WB+1. Exactly two ctrl_MULT pulses and two writebacks occur.
- reset asserted in BUSY, then RDY arrives -> all outputs 0 immediately; no writeback; state is IDLE.
- With MD_TIMEOUT_EN, TIMEOUT_CYCLES = 40, RDY never asserts -> WB after 40 BUSY cycles writes r30 = 4 for a mul. stall drops in that WB cycle.
